// File: rtl/tank_pkg.sv
// Shared tile-map types and constants for the tank game playfield.
package tank_pkg;

  localparam int unsigned TILE_SHIFT     = 5;
  localparam int unsigned MAP_W          = 20;
  localparam int unsigned MAP_H          = 15;
  localparam int unsigned MAP_N          = MAP_W * MAP_H;
  localparam int unsigned MAP_BITS       = 2 * MAP_N;
  localparam int unsigned DEFAULT_ROW    = 7;
  localparam int unsigned DEFAULT_BRICKS = 10;

  typedef enum logic [1:0] {
    TILE_EMPTY = 2'd0,
    TILE_BRICK = 2'd1,
    TILE_IRON  = 2'd2
  } tile_t;

  // Row 7: bricks at cols 4..8 and 11..15, iron at col 10.
  function automatic logic [MAP_BITS-1:0] build_default_map();
    logic [MAP_BITS-1:0] m;
    m = '0;
    for (int unsigned c = 4; c <= 8; c++)
      m[2*(DEFAULT_ROW*MAP_W+c) +: 2] = 2'(TILE_BRICK);
    for (int unsigned c = 11; c <= 15; c++)
      m[2*(DEFAULT_ROW*MAP_W+c) +: 2] = 2'(TILE_BRICK);
    m[2*(DEFAULT_ROW*MAP_W+10) +: 2] = 2'(TILE_IRON);
    return m;
  endfunction

  localparam logic [MAP_BITS-1:0] DEFAULT_MAP = build_default_map();

  function automatic logic pix_in_map(input logic [9:0] x, input logic [9:0] y);
    return (x < 10'(MAP_W << TILE_SHIFT)) && (y < 10'(MAP_H << TILE_SHIFT));
  endfunction

  function automatic logic [8:0] pix_to_index(input logic [9:0] x, input logic [9:0] y);
    return 9'(y >> TILE_SHIFT) * 9'(MAP_W) + 9'(x >> TILE_SHIFT);
  endfunction

endpackage

// File: rtl/tile_map.sv
// Destructible tile storage: one clear-to-empty write port, default-load strobe,
// and two pixel-addressed combinational read ports.
module tile_map
  import tank_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_load,
  input  logic       i_clr,
  input  logic [9:0] i_clr_x,
  input  logic [9:0] i_clr_y,
  input  logic [9:0] i_bul_x,
  input  logic [9:0] i_bul_y,
  output tile_t      o_bul_tile,
  input  logic [9:0] i_drw_x,
  input  logic [9:0] i_drw_y,
  output tile_t      o_drw_tile
);

  logic [MAP_BITS-1:0] r_map;
  logic [8:0]          w_clr_idx;
  logic [8:0]          w_bul_idx;
  logic [8:0]          w_drw_idx;

  assign w_clr_idx = pix_to_index(i_clr_x, i_clr_y);
  assign w_bul_idx = pix_to_index(i_bul_x, i_bul_y);
  assign w_drw_idx = pix_to_index(i_drw_x, i_drw_y);

  always_ff @(posedge i_clk) begin
    if (i_load)
      r_map <= DEFAULT_MAP;
    else if (i_clr && pix_in_map(i_clr_x, i_clr_y))
      r_map[{w_clr_idx, 1'b0} +: 2] <= 2'(TILE_EMPTY);
  end

  // Pixels outside the 640x480 field read as empty.
  always_comb begin
    o_bul_tile = TILE_EMPTY;
    o_drw_tile = TILE_EMPTY;
    if (pix_in_map(i_bul_x, i_bul_y))
      o_bul_tile = tile_t'(r_map[{w_bul_idx, 1'b0} +: 2]);
    if (pix_in_map(i_drw_x, i_drw_y))
      o_drw_tile = tile_t'(r_map[{w_drw_idx, 1'b0} +: 2]);
  end

endmodule

// File: rtl/bullet_hit_detect.sv
// Bullet collision feedback for the bullet engine; owns the tile map,
// remaining-brick count and the target tank's lives.
module bullet_hit_detect
  import tank_pkg::*;
#(
  parameter int unsigned LIVES_INIT = 3
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       gamebegin_on,
  input  logic       gaming_on,
  input  logic       Is_bullet_on,
  input  logic [9:0] BulletX,
  input  logic [9:0] BulletY,
  input  logic [9:0] BulletS,
  input  logic [9:0] BulletX_Motion,
  input  logic [9:0] BulletY_Motion,
  input  logic [9:0] TankX,
  input  logic [9:0] TankY,
  input  logic [9:0] TankS,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       HitWall,
  output logic       HitIron,
  output logic       BulletHittank,
  output logic [1:0] TileType,
  output logic [1:0] Lives,
  output logic       tank_dead,
  output logic [8:0] brick_count
);

  logic        r_armed;
  logic [1:0]  r_lives;
  logic        r_tank_dead;
  logic [8:0]  r_brick_count;

  logic [9:0]  w_nx;
  logic [9:0]  w_ny;
  logic        w_reload;
  logic        w_qual;
  logic        w_tank_raw;
  logic        w_any_hit;
  tile_t       w_bul_tile;
  tile_t       w_drw_tile;

  logic signed [11:0] w_dx;
  logic signed [11:0] w_dy;
  logic signed [11:0] w_adx;
  logic signed [11:0] w_ady;
  logic signed [11:0] w_reach;

  // The bullet engine tests the same next point, so hits land on entry.
  assign w_nx = BulletX + BulletX_Motion;
  assign w_ny = BulletY + BulletY_Motion;

  assign w_reload = !Reset_n || gamebegin_on;
  assign w_qual   = Reset_n && !gamebegin_on && gaming_on && Is_bullet_on && r_armed;

  assign w_dx    = $signed({2'b00, w_nx}) - $signed({2'b00, TankX});
  assign w_dy    = $signed({2'b00, w_ny}) - $signed({2'b00, TankY});
  assign w_adx   = w_dx[11] ? -w_dx : w_dx;
  assign w_ady   = w_dy[11] ? -w_dy : w_dy;
  assign w_reach = $signed({2'b00, TankS}) + $signed({2'b00, BulletS});
  assign w_tank_raw = (w_adx <= w_reach) && (w_ady <= w_reach);

  // Tank wins over iron, iron over brick; at most one output is high.
  assign BulletHittank = w_qual && w_tank_raw;
  assign HitIron       = w_qual && !w_tank_raw && (w_bul_tile == TILE_IRON);
  assign HitWall       = w_qual && !w_tank_raw && (w_bul_tile == TILE_BRICK);
  assign w_any_hit     = BulletHittank || HitIron || HitWall;

  tile_map u_tile_map (
    .i_clk      (frame_clk),
    .i_load     (w_reload),
    .i_clr      (HitWall),
    .i_clr_x    (w_nx),
    .i_clr_y    (w_ny),
    .i_bul_x    (w_nx),
    .i_bul_y    (w_ny),
    .o_bul_tile (w_bul_tile),
    .i_drw_x    (DrawX),
    .i_drw_y    (DrawY),
    .o_drw_tile (w_drw_tile)
  );

  always_ff @(posedge frame_clk) begin
    if (w_reload) begin
      r_armed       <= 1'b1;
      r_lives       <= 2'(LIVES_INIT);
      r_tank_dead   <= 1'b0;
      r_brick_count <= 9'(DEFAULT_BRICKS);
    end else begin
      if (HitWall && (r_brick_count != 9'd0))
        r_brick_count <= r_brick_count - 9'd1;
      // Lives saturate at zero; the bullet still stops on a dead tank.
      if (BulletHittank && (r_lives != 2'd0)) begin
        r_lives <= r_lives - 2'd1;
        if (r_lives == 2'd1)
          r_tank_dead <= 1'b1;
      end
      if (w_any_hit)
        r_armed <= 1'b0;
      else if (!Is_bullet_on)
        r_armed <= 1'b1;
    end
  end

  assign TileType    = 2'(w_drw_tile);
  assign Lives       = r_lives;
  assign tank_dead   = r_tank_dead;
  assign brick_count = r_brick_count;

endmodule
